// File: rtl/vmem_sched_pkg.sv
// Shared types and widths for the video-memory scheduler.
package vmem_sched_pkg;

    localparam int unsigned PIX_W  = 12;
    localparam int unsigned LINE_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_DRAIN = 2'd2,
        ST_WR_ISSUE = 2'd3
    } state_e;

endpackage

// File: rtl/vmem_addr_gen.sv
// Frame-memory word address: line * LINE_WORDS + word, wrapped to ADDR_W bits.
module vmem_addr_gen
    import vmem_sched_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 320,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned WORD_W     = 9
) (
    input  logic [LINE_W-1:0] line_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [ADDR_W-1:0] addr_o
);

    assign addr_o = ADDR_W'(line_i) * ADDR_W'(LINE_WORDS) + ADDR_W'(word_i);

endmodule

// File: rtl/vmem_sched.sv
// Arbitrates one memory port between display line prefetch (into a ping-pong
// line buffer) and capture line write-back; display fetch has priority.
module vmem_sched
    import vmem_sched_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 320,
    parameter int unsigned ADDR_W     = 18
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_line_end,
    input  logic [LINE_W-1:0] i_line_idx,
    input  logic              i_frame_end,
    input  logic              i_cap_req,
    input  logic [LINE_W-1:0] i_cap_line,
    output logic              o_cap_rd,
    input  logic [PIX_W-1:0]  i_cap_data,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [PIX_W-1:0]  o_mem_wdata,
    input  logic              i_mem_rdy,
    input  logic              i_mem_rvalid,
    input  logic [PIX_W-1:0]  i_mem_rdata,
    output logic              o_lb_we,
    output logic [LINE_W-1:0] o_lb_addr,
    output logic [PIX_W-1:0]  o_lb_data,
    output logic              o_lb_bank,
    output logic              o_underrun,
    input  logic              i_clr
);

    localparam int unsigned     CNT_W     = $clog2(LINE_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(LINE_WORDS);

    state_e              state_q, state_d;
    logic                line_end_q;
    logic                pend_q, pend_d;
    logic [LINE_W-1:0]   tgt_q, tgt_d;
    logic [LINE_W-1:0]   rd_line_q, rd_line_d;
    logic [LINE_W-1:0]   cap_line_q, cap_line_d;
    logic [CNT_W-1:0]    cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic                bank_q, bank_d;
    logic                underrun_q, underrun_d;
    logic                lb_we_q, lb_we_d;
    logic [LINE_W-1:0]   lb_addr_q, lb_addr_d;
    logic [PIX_W-1:0]    lb_data_q, lb_data_d;

    logic                trig, in_rd, rx, accept;
    logic [LINE_W-1:0]   tgt_new, ag_line;
    logic [ADDR_W-1:0]   ag_addr;

    assign trig      = i_line_end && !line_end_q;
    assign tgt_new   = i_frame_end ? '0 : i_line_idx + LINE_W'(1);
    assign in_rd     = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_DRAIN);
    assign rx        = i_mem_rvalid && in_rd;
    assign o_mem_req = (state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE);
    assign o_mem_we  = (state_q == ST_WR_ISSUE);
    assign accept    = o_mem_req && i_mem_rdy;
    assign o_cap_rd  = o_mem_we && i_mem_rdy;
    assign ag_line   = o_mem_we ? cap_line_q : rd_line_q;

    vmem_addr_gen #(
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W),
        .WORD_W     (CNT_W)
    ) u_addr_gen (
        .line_i (ag_line),
        .word_i (cmd_cnt_q),
        .addr_o (ag_addr)
    );

    assign o_mem_addr  = o_mem_req ? ag_addr : '0;
    assign o_mem_wdata = o_mem_we ? i_cap_data : '0;
    assign o_lb_we     = lb_we_q;
    assign o_lb_addr   = lb_addr_q;
    assign o_lb_data   = lb_data_q;
    assign o_lb_bank   = bank_q;
    assign o_underrun  = underrun_q;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        tgt_d      = tgt_q;
        rd_line_d  = rd_line_q;
        cap_line_d = cap_line_q;
        cmd_cnt_d  = cmd_cnt_q;
        ret_cnt_d  = ret_cnt_q;
        bank_d     = bank_q;
        underrun_d = underrun_q;
        lb_we_d    = rx;
        lb_addr_d  = lb_addr_q;
        lb_data_d  = lb_data_q;

        if (rx) begin
            lb_addr_d = LINE_W'(ret_cnt_q);
            lb_data_d = i_mem_rdata;
            ret_cnt_d = ret_cnt_q + CNT_W'(1);
        end

        // A trigger is folded into pend_d first so IDLE can start the fetch in
        // the same cycle; an unstarted pending target is simply overwritten.
        if (trig) begin
            bank_d = !bank_q;
            pend_d = 1'b1;
            tgt_d  = tgt_new;
        end

        if (trig && (pend_q || in_rd)) begin
            underrun_d = 1'b1;
        end else if (i_clr) begin
            underrun_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pend_d) begin
                    state_d   = ST_RD_ISSUE;
                    pend_d    = 1'b0;
                    rd_line_d = tgt_d;
                    cmd_cnt_d = '0;
                    ret_cnt_d = '0;
                end else if (i_cap_req) begin
                    state_d    = ST_WR_ISSUE;
                    cap_line_d = i_cap_line;
                    cmd_cnt_d  = '0;
                end
            end
            ST_RD_ISSUE: begin
                if (accept) begin
                    cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
                    if (cmd_cnt_q == LAST_WORD) begin
                        state_d = ST_RD_DRAIN;
                    end
                end
            end
            ST_RD_DRAIN: begin
                if (ret_cnt_d == ALL_WORDS) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ISSUE: begin
                if (accept) begin
                    cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
                    if (cmd_cnt_q == LAST_WORD) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            line_end_q <= 1'b0;
            pend_q     <= 1'b0;
            tgt_q      <= '0;
            rd_line_q  <= '0;
            cap_line_q <= '0;
            cmd_cnt_q  <= '0;
            ret_cnt_q  <= '0;
            bank_q     <= 1'b0;
            underrun_q <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_addr_q  <= '0;
            lb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            line_end_q <= i_line_end;
            pend_q     <= pend_d;
            tgt_q      <= tgt_d;
            rd_line_q  <= rd_line_d;
            cap_line_q <= cap_line_d;
            cmd_cnt_q  <= cmd_cnt_d;
            ret_cnt_q  <= ret_cnt_d;
            bank_q     <= bank_d;
            underrun_q <= underrun_d;
            lb_we_q    <= lb_we_d;
            lb_addr_q  <= lb_addr_d;
            lb_data_q  <= lb_data_d;
        end
    end

endmodule

// File: tb/tb_vmem_sched.sv
// Bench for vmem_sched: memory/capture-FIFO model plus line-level reference.
module tb_vmem_sched;

    localparam int LW = 320;
    localparam int AW = 18;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          line_end  = 1'b0;
    logic [8:0]    line_idx  = '0;
    logic          frame_end = 1'b0;
    logic          cap_req   = 1'b0;
    logic [8:0]    cap_line  = '0;
    logic          clr       = 1'b0;
    logic [11:0]   cap_data  = '0;
    logic          mem_rdy    = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [11:0]   mem_rdata  = '0;
    logic          cap_rd, mem_req, mem_we, lb_we, lb_bank, underrun;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_wdata, lb_data;
    logic [8:0]    lb_addr;

    always #5 clk = ~clk;

    vmem_sched #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_line_end(line_end), .i_line_idx(line_idx),
        .i_frame_end(frame_end), .i_cap_req(cap_req), .i_cap_line(cap_line),
        .o_cap_rd(cap_rd), .i_cap_data(cap_data), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdy(mem_rdy),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_lb_we(lb_we),
        .o_lb_addr(lb_addr), .o_lb_data(lb_data), .o_lb_bank(lb_bank),
        .o_underrun(underrun), .i_clr(clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_target(input int idx, input bit fe);
        return fe ? 0 : (idx + 1) % 512;
    endfunction

    function automatic int model_addr(input int line, input int w);
        return (line * LW + w) % (1 << AW);
    endfunction

    function automatic logic [11:0] mem_val(input int a);
        logic [31:0] t;
        t = a;
        return t[11:0] ^ 12'h5A3;
    endfunction

    // ---------------- memory port and capture FIFO model ----------------
    int cyc = 0;
    int rd_log[$], rd_cyc[$], wr_log[$], wr_dat[$], wr_cyc[$], lb_a[$], lb_d[$];
    int due_q[$];
    logic [11:0] dat_q[$];
    int last_due = 0, stall_viol = 0, caprd_viol = 0, caprd_cnt = 0, due = 0;
    bit rdy_rand = 0, lat_rand = 0, pop_pend = 0, held = 0;
    int fixed_lat = 3;
    logic [AW-1:0] h_addr = '0;
    logic          h_we = 1'b0;
    logic [11:0]   h_wdata = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            due_q.delete();
            dat_q.delete();
            pop_pend   = 0;
            held       = 0;
            mem_rvalid = 1'b0;
            mem_rdy    = 1'b0;
            last_due   = cyc;
        end else begin
            if (pop_pend) begin
                cap_data = cap_data + 12'd1;
                pop_pend = 0;
            end
            if (lb_we) begin
                lb_a.push_back(int'(lb_addr));
                lb_d.push_back(int'(lb_data));
            end
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = dat_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 12'($urandom);
            end
            #1;
            if (held && (!mem_req || mem_addr !== h_addr || mem_we !== h_we ||
                         (h_we && mem_wdata !== h_wdata)))
                stall_viol++;
            mem_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cap_rd !== (mem_req && mem_rdy && mem_we)) caprd_viol++;
            if (cap_rd) caprd_cnt++;
            held    = mem_req && !mem_rdy;
            h_addr  = mem_addr;
            h_we    = mem_we;
            h_wdata = mem_wdata;
            if (mem_req && mem_rdy) begin
                if (mem_we) begin
                    wr_log.push_back(int'(mem_addr));
                    wr_dat.push_back(int'(mem_wdata));
                    wr_cyc.push_back(cyc);
                    pop_pend = 1;
                end else begin
                    rd_log.push_back(int'(mem_addr));
                    rd_cyc.push_back(cyc);
                    due = cyc + (lat_rand ? int'($urandom_range(1, 6)) : fixed_lat);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    due_q.push_back(due);
                    dat_q.push_back(mem_val(int'(mem_addr)));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic int qsize(input int which);
        case (which)
            0: return rd_log.size();
            1: return wr_log.size();
            default: return lb_a.size();
        endcase
    endfunction

    function automatic int qget(input int which, input int i);
        case (which)
            0: return (i < rd_log.size()) ? rd_log[i] : -1;
            1: return (i < wr_log.size()) ? wr_log[i] : -1;
            2: return (i < wr_dat.size()) ? wr_dat[i] : -1;
            3: return (i < lb_a.size())   ? lb_a[i]   : -1;
            4: return (i < lb_d.size())   ? lb_d[i]   : -1;
            5: return (i < rd_cyc.size()) ? rd_cyc[i] : -1;
            default: return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
        endcase
    endfunction

    task automatic wait_size(input int which, input int need, input int budget, input string name);
        int n = 0;
        while (qsize(which) < need && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (qsize(which) < need) check({name, "_timeout"}, qsize(which), need);
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 40 && n < budget) begin
            @(negedge clk);
            #3;
            n++;
            if (mem_req || lb_we || due_q.size() > 0) quiet = 0;
            else quiet++;
        end
        check({name, "_quiet"}, longint'(quiet >= 40), 1);
    endtask

    task automatic pulse_line(input logic [8:0] idx, input bit fe);
        line_idx  = idx;
        frame_end = fe;
        line_end  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        line_end  = 1'b0;
    endtask

    task automatic check_fetch(input string tag, input int r0, input int l0, input int tgt, input int nlines);
        int bad_rd = 0;
        int bad_lb = 0;
        check({tag, "_rd_count"}, qsize(0) - r0, nlines * LW);
        check({tag, "_lb_count"}, qsize(2) - l0, nlines * LW);
        for (int i = 0; i < LW; i++) begin
            if (qget(0, r0 + i) != model_addr(tgt, i)) bad_rd++;
            if (qget(3, l0 + i) != i || qget(4, l0 + i) != int'(mem_val(model_addr(tgt, i)))) bad_lb++;
        end
        check({tag, "_rd_addr_bad"}, bad_rd, 0);
        check({tag, "_lb_bad"}, bad_lb, 0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [8:0] idx;
        bit         fe;
        bit         cap;
        logic [8:0] cline;
        bit         rnd;
        int         exp_rd;
        int         exp_wr;
        bit         exp_bank;
    } vec_t;

    vec_t vecs[5];
    int r0, w0, l0, c0, sv0, cv0, seed, tgt, bad, w1;

    initial begin
        vecs[0] = '{idx: 9'd5,   fe: 1'b0, cap: 1'b0, cline: 9'd0,   rnd: 1'b0, exp_rd: 1920,  exp_wr: 0,     exp_bank: 1'b1};
        vecs[1] = '{idx: 9'd479, fe: 1'b1, cap: 1'b0, cline: 9'd0,   rnd: 1'b0, exp_rd: 0,     exp_wr: 0,     exp_bank: 1'b0};
        vecs[2] = '{idx: 9'd20,  fe: 1'b0, cap: 1'b1, cline: 9'd10,  rnd: 1'b0, exp_rd: 6720,  exp_wr: 3200,  exp_bank: 1'b1};
        vecs[3] = '{idx: 9'd100, fe: 1'b0, cap: 1'b0, cline: 9'd0,   rnd: 1'b1, exp_rd: 32320, exp_wr: 0,     exp_bank: 1'b0};
        vecs[4] = '{idx: 9'd511, fe: 1'b0, cap: 1'b1, cline: 9'd200, rnd: 1'b1, exp_rd: 0,     exp_wr: 64000, exp_bank: 1'b1};

        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", longint'({mem_req, mem_we, mem_addr, mem_wdata, cap_rd, lb_we,
                                          lb_addr, lb_data, lb_bank, underrun}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            rdy_rand  = vecs[k].rnd;
            lat_rand  = vecs[k].rnd;
            fixed_lat = 3;
            @(negedge clk);
            #3;
            r0 = qsize(0); w0 = qsize(1); l0 = qsize(2);
            c0 = caprd_cnt; sv0 = stall_viol; cv0 = caprd_viol; seed = int'(cap_data);
            tgt = model_target(int'(vecs[k].idx), vecs[k].fe);
            cap_line = vecs[k].cline;
            cap_req  = vecs[k].cap;
            pulse_line(vecs[k].idx, vecs[k].fe);
            if (vecs[k].cap) begin
                wait_size(1, w0 + 1, 3000, "wr_start");
                cap_req = 1'b0;
            end
            wait_quiet(8000, "vec");
            check("vec_bank", longint'(lb_bank), longint'(vecs[k].exp_bank));
            check("vec_underrun", longint'(underrun), 0);
            check("vec_rd_first", qget(0, r0), vecs[k].exp_rd);
            check_fetch("vec", r0, l0, tgt, 1);
            if (vecs[k].cap) begin
                bad = 0;
                for (int i = 0; i < LW; i++) begin
                    if (qget(1, w0 + i) != model_addr(int'(vecs[k].cline), i)) bad++;
                    if (qget(2, w0 + i) != (seed + i) % 4096) bad++;
                end
                check("wr_count", qsize(1) - w0, LW);
                check("wr_first", qget(1, w0), vecs[k].exp_wr);
                check("wr_bad", bad, 0);
                check("cap_rd_pulses", caprd_cnt - c0, LW);
                check("rd_before_wr", longint'(qget(5, r0 + LW - 1) < qget(6, w0)), 1);
            end
            check("stall_hold_viol", stall_viol - sv0, 0);
            check("cap_rd_viol", caprd_viol - cv0, 0);
        end

        // Retrigger while the previous fetch is draining.
        rdy_rand = 0; lat_rand = 0; fixed_lat = 20;
        @(negedge clk);
        r0 = qsize(0); l0 = qsize(2);
        pulse_line(9'd2, 1'b0);
        wait_size(0, r0 + LW, 2000, "urun_issue");
        @(negedge clk);
        @(negedge clk);
        pulse_line(9'd9, 1'b0);
        check("underrun_set", longint'(underrun), 1);
        wait_quiet(4000, "urun");
        check("underrun_sticky", longint'(underrun), 1);
        check_fetch("urun_first", r0, l0, 3, 2);
        check("urun_second_base", qget(0, r0 + LW), 3200);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("underrun_clr", longint'(underrun), 0);

        // Clear asserted in the very cycle an overlapping trigger is seen.
        @(negedge clk);
        r0 = qsize(0);
        pulse_line(9'd30, 1'b0);
        wait_size(0, r0 + 50, 2000, "ovl_issue");
        @(negedge clk);
        clr      = 1'b1;
        line_idx = 9'd40;
        line_end = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("underrun_set_wins", longint'(underrun), 1);
        @(negedge clk);
        line_end = 1'b0;
        wait_quiet(4000, "ovl");
        check("ovl_rd_count", qsize(0) - r0, 2 * LW);
        check("ovl_second_base", qget(0, r0 + LW), 13120);

        // Reset in the middle of a capture write burst.
        fixed_lat = 3;
        @(negedge clk);
        w0 = qsize(1);
        cap_line = 9'd3;
        cap_req  = 1'b1;
        wait_size(1, w0 + 100, 2000, "wr_progress");
        cap_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("midrst_outputs", longint'({mem_req, mem_we, mem_addr, mem_wdata, cap_rd, lb_we,
                                           lb_addr, lb_data, lb_bank, underrun}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w1 = qsize(1);
        repeat (20) @(negedge clk);
        check("no_write_after_rst", qsize(1) - w1, 0);
        @(negedge clk);
        #3;
        r0 = qsize(0); l0 = qsize(2);
        pulse_line(9'd7, 1'b0);
        wait_quiet(4000, "postrst");
        check("postrst_rd_first", qget(0, r0), 2560);
        check_fetch("postrst", r0, l0, 8, 1);
        check("postrst_bank", longint'(lb_bank), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

endmodule
